// File: rtl/dht22_poll_scheduler.sv
// Read scheduler for the DHT22 front end: periodic/manual triggering, minimum inter-read gap,
// transaction timeout, automatic retry and a hold register for the last accepted sample.
module dht22_poll_scheduler #(
  parameter int CLK_FREQ       = 100000000,
  parameter int POLL_PERIOD_US = 2000000,
  parameter int MIN_GAP_US     = 2000000,
  parameter int TIMEOUT_US     = 10000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        enable,
  input  logic        manual_req,
  output logic        start_read,
  input  logic        sys_idle,
  input  logic        data_ready,
  input  logic [11:0] humidity_bcd_in,
  input  logic [11:0] temp_bcd_in,
  input  logic        temp_neg_in,
  output logic [11:0] humidity_bcd,
  output logic [11:0] temp_bcd,
  output logic        temp_neg,
  output logic        sample_valid,
  output logic        have_sample,
  output logic        busy,
  output logic [3:0]  fail_count,
  output logic        sensor_fault
);

  localparam int TICK_DIV = (CLK_FREQ >= 2000000) ? (CLK_FREQ / 1000000) : 1;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int POLL_W   = ($clog2(POLL_PERIOD_US + 1) > 20) ? $clog2(POLL_PERIOD_US + 1) : 20;
  localparam int GAP_W    = $clog2(MIN_GAP_US + 2);
  localparam int TMO_W    = $clog2(TIMEOUT_US + 2);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
  localparam logic [POLL_W-1:0] POLL_LIM  = POLL_W'(POLL_PERIOD_US);
  localparam logic [POLL_W-1:0] POLL_ONE  = POLL_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LIM   = GAP_W'(MIN_GAP_US);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LIM   = TMO_W'(TIMEOUT_US);
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
  localparam logic [3:0]        RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_WAIT_IDLE
  } state_t;

  state_t             state_reg;
  logic [PRE_W-1:0]   pre_cnt_reg;
  logic [POLL_W-1:0]  poll_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic               poll_pend_reg;
  logic               man_pend_reg;
  logic               gap_ok_reg;

  logic               tick;
  logic               launch;
  logic               idle_return;
  logic               tmo_hit;
  logic               frame_ok;
  logic               read_fail;
  logic               retry;
  logic [3:0]         fail_next;
  logic [23:0]        frame_digits;
  logic [5:0]         digit_ok;

  assign tick        = (pre_cnt_reg == PRE_LAST);
  assign launch      = (state_reg == ST_IDLE) && (poll_pend_reg || man_pend_reg) && gap_ok_reg && sys_idle;
  assign idle_return = (state_reg == ST_WAIT_IDLE) && sys_idle;
  assign tmo_hit     = (tmo_cnt_reg == TMO_LIM);

  // A frame is accepted only when all six BCD digits are decimal.
  assign frame_digits = {humidity_bcd_in, temp_bcd_in};
  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    assign digit_ok[gi] = (frame_digits[gi*4 +: 4] <= 4'd9);
  end
  assign frame_ok = &digit_ok;

  assign read_fail = (state_reg == ST_WAIT_DONE) && ((data_ready && !frame_ok) || (!data_ready && tmo_hit));
  assign fail_next = (fail_count == 4'hF) ? 4'hF : (fail_count + 4'd1);
  assign retry     = read_fail && (fail_next < RETRY_LIM);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= tick ? '0 : (pre_cnt_reg + PRE_ONE);
    end
  end

  // Poll timer measures start to start and saturates at the period.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      poll_cnt_reg  <= '0;
      poll_pend_reg <= 1'b0;
    end else begin
      if (launch) begin
        poll_cnt_reg <= '0;
      end else if (tick && (poll_cnt_reg != POLL_LIM)) begin
        poll_cnt_reg <= poll_cnt_reg + POLL_ONE;
      end
      if (!enable || launch) begin
        poll_pend_reg <= 1'b0;
      end else if (poll_cnt_reg == POLL_LIM) begin
        poll_pend_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      man_pend_reg <= 1'b0;
    end else if (manual_req || retry) begin
      man_pend_reg <= 1'b1;
    end else if (launch) begin
      man_pend_reg <= 1'b0;
    end
  end

  // Gap timer restarts on each return to idle; gap_ok starts set so the first read is not delayed.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      gap_cnt_reg <= '0;
      gap_ok_reg  <= 1'b1;
    end else if (idle_return) begin
      gap_cnt_reg <= '0;
      gap_ok_reg  <= 1'b0;
    end else begin
      if (tick && (gap_cnt_reg != GAP_LIM)) begin
        gap_cnt_reg <= gap_cnt_reg + GAP_ONE;
      end
      if (gap_cnt_reg == GAP_LIM) begin
        gap_ok_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_START) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == ST_WAIT_DONE) && tick && !tmo_hit) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_ONE;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_reg    <= ST_IDLE;
      start_read   <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      humidity_bcd <= '0;
      temp_bcd     <= '0;
      temp_neg     <= 1'b0;
      have_sample  <= 1'b0;
      fail_count   <= '0;
      sensor_fault <= 1'b0;
    end else begin
      start_read   <= 1'b0;
      sample_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            state_reg  <= ST_START;
            start_read <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_START: begin
          state_reg <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // data_ready takes precedence over a timeout in the same cycle.
          if (data_ready && frame_ok) begin
            humidity_bcd <= humidity_bcd_in;
            temp_bcd     <= temp_bcd_in;
            temp_neg     <= temp_neg_in;
            sample_valid <= 1'b1;
            have_sample  <= 1'b1;
            fail_count   <= '0;
            sensor_fault <= 1'b0;
            state_reg    <= ST_WAIT_IDLE;
          end else if (read_fail) begin
            fail_count   <= fail_next;
            sensor_fault <= (fail_next >= RETRY_LIM);
            state_reg    <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (sys_idle) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht22_poll_scheduler.sv
// Directed bench for dht22_poll_scheduler with a behavioural top_dht22 responder.
`timescale 1ns/1ps
module tb_dht22_poll_scheduler;

  localparam int CLK_FREQ = 1000000;
  localparam int POLL     = 3000;
  localparam int GAP      = 2000;
  localparam int TMO      = 10000;
  localparam int RETRIES  = 2;

  localparam int M_GOOD = 0;
  localparam int M_HANG = 1;
  localparam int M_TIE  = 2;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        enable = 1'b0;
  logic        manual_req = 1'b0;
  logic        sys_idle = 1'b1;
  logic        data_ready = 1'b0;
  logic [11:0] humidity_bcd_in = '0;
  logic [11:0] temp_bcd_in = '0;
  logic        temp_neg_in = 1'b0;
  logic        start_read;
  logic [11:0] humidity_bcd;
  logic [11:0] temp_bcd;
  logic        temp_neg;
  logic        sample_valid;
  logic        have_sample;
  logic        busy;
  logic [3:0]  fail_count;
  logic        sensor_fault;

  dht22_poll_scheduler #(
    .CLK_FREQ(CLK_FREQ), .POLL_PERIOD_US(POLL), .MIN_GAP_US(GAP),
    .TIMEOUT_US(TMO), .MAX_RETRIES(RETRIES)
  ) dut (
    .clk(clk), .arstn(arstn), .enable(enable), .manual_req(manual_req),
    .start_read(start_read), .sys_idle(sys_idle), .data_ready(data_ready),
    .humidity_bcd_in(humidity_bcd_in), .temp_bcd_in(temp_bcd_in), .temp_neg_in(temp_neg_in),
    .humidity_bcd(humidity_bcd), .temp_bcd(temp_bcd), .temp_neg(temp_neg),
    .sample_valid(sample_valid), .have_sample(have_sample), .busy(busy),
    .fail_count(fail_count), .sensor_fault(sensor_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int start_count = 0;
  int sv_count = 0;
  int last_start = 0;
  int last_sv = 0;
  int last_dr = 0;
  int last_idle = 0;
  logic busy_q = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  int mode = M_GOOD;
  logic [11:0] frame_hum = 12'h654;
  logic [11:0] frame_temp = 12'h213;
  logic frame_neg = 1'b1;
  int poke_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_q <= busy;
    if (start_read) begin
      start_count <= start_count + 1;
      last_start  <= cyc;
      $display("read %0d issued at cycle %0d (mode %0d)", start_count + 1, cyc, mode);
    end
    if (sample_valid) begin
      sv_count <= sv_count + 1;
      last_sv  <= cyc;
      $display("sample at cycle %0d: rh=%03h t=%03h neg=%0b", cyc, humidity_bcd, temp_bcd, temp_neg);
    end
    if (data_ready) last_dr <= cyc;
    if (busy_q && !busy) last_idle <= cyc;
  end

  // Behavioural top_dht22: drops sys_idle on start_read, answers per mode, then returns idle.
  initial begin
    int poke_seen;
    int lim;
    poke_seen = 0;
    forever begin
      @(negedge clk);
      if (start_read && arstn) begin
        sys_idle = 1'b0;
        if (mode == M_HANG) begin
          for (int k = 0; k < 12000 && arstn; k++) @(negedge clk);
        end else begin
          lim = (mode == M_TIE) ? (TMO + 1) : 200;
          for (int k = 0; k < lim && arstn; k++) @(negedge clk);
          if (arstn) begin
            humidity_bcd_in = frame_hum;
            temp_bcd_in     = frame_temp;
            temp_neg_in     = frame_neg;
            data_ready      = 1'b1;
            @(negedge clk);
            data_ready = 1'b0;
            repeat (9) @(negedge clk);
          end
        end
        sys_idle = 1'b1;
      end else if (poke_cnt != poke_seen) begin
        poke_seen       = poke_cnt;
        humidity_bcd_in = frame_hum;
        temp_bcd_in     = frame_temp;
        temp_neg_in     = frame_neg;
        data_ready      = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic pulse_manual();
    manual_req = 1'b1;
    step(1);
    manual_req = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int base, input int limit);
    int n = 0;
    while (start_count <= base && n < limit) begin step(1); n++; end
    chk(tag, start_count > base, 1);
  endtask

  task automatic wait_sv(input string tag, input int base, input int limit);
    int n = 0;
    while (sv_count <= base && n < limit) begin step(1); n++; end
    chk(tag, sv_count > base, 1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin step(1); n++; end
    chk(tag, busy, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sv0;
    int s0;
    int f;
    step(5);
    chk("rst_bcd", {humidity_bcd, temp_bcd}, 48'h0);
    chk("rst_flags", {temp_neg, sample_valid, have_sample, busy, fail_count, sensor_fault, start_read}, 48'h0);
    arstn  = 1'b1;
    enable = 1'b1;

    // 1: periodic polling, start to start = period plus the 2-cycle launch latency
    base = start_count; sv0 = sv_count;
    wait_start("t1_first_start", base, POLL + 100);
    s0 = last_start;
    wait_sv("t1_first_sample", sv0, 400);
    chk("t1_sv_latency", last_sv - last_dr, 1);
    chk("t1_hum", humidity_bcd, 12'h654);
    chk("t1_temp", temp_bcd, 12'h213);
    chk("t1_neg", temp_neg, 1);
    chk("t1_fail_have", {fail_count, have_sample, sensor_fault}, {4'd0, 1'b1, 1'b0});
    wait_start("t1_second_start", base + 1, POLL + 100);
    chk("t1_period_a", last_start - s0, POLL + 2);
    s0 = last_start;
    wait_start("t1_third_start", base + 2, POLL + 100);
    chk("t1_period_b", last_start - s0, POLL + 2);

    // 2: manual request 500 us after the end of a read waits out the gap
    wait_idle("t2_idle", 400);
    enable = 1'b0;
    f = last_idle;
    step_to(f + 500);
    base = start_count;
    pulse_manual();
    wait_start("t2_man_start", base, GAP + 100);
    chk("t2_gap", last_start - f, GAP + 2);
    step_to(last_start + 50);
    chk("t2_busy", busy, 1);
    pulse_manual();
    wait_idle("t2_idle2", 400);
    f = last_idle;
    wait_start("t2_extra_start", base + 1, GAP + 100);
    chk("t2_extra_gap", last_start - f, GAP + 2);
    step(4000);
    chk("t2_read_count", start_count - base, 2);

    // 3: hung reads time out, retry once, then fault while holding the last sample
    mode = M_HANG;
    base = start_count;
    pulse_manual();
    wait_start("t3_start", base, 100);
    s0 = last_start;
    step_to(s0 + TMO - 10);
    chk("t3_fail_pre_tmo", fail_count, 0);
    step_to(s0 + TMO + 10);
    chk("t3_fail_1", fail_count, 1);
    chk("t3_fault_0", sensor_fault, 0);
    wait_idle("t3_idle", 2500);
    f = last_idle;
    wait_start("t3_retry_start", base + 1, GAP + 100);
    chk("t3_retry_gap", last_start - f, GAP + 2);
    s0 = last_start;
    step_to(s0 + TMO + 10);
    chk("t3_fail_2", fail_count, 2);
    chk("t3_fault_1", sensor_fault, 1);
    chk("t3_held", {humidity_bcd, temp_bcd, temp_neg}, {12'h654, 12'h213, 1'b1});
    wait_idle("t3_idle2", 2500);
    base = start_count;
    step(GAP + 500);
    chk("t3_no_retry", start_count - base, 0);

    // 4: a good frame clears the fault; data_ready while idle is ignored
    mode = M_GOOD; frame_hum = 12'h499; frame_temp = 12'h187; frame_neg = 1'b0;
    sv0 = sv_count;
    pulse_manual();
    wait_sv("t4_sample", sv0, 600);
    chk("t4_clear", {fail_count, sensor_fault}, {4'd0, 1'b0});
    chk("t4_out", {humidity_bcd, temp_bcd, temp_neg}, {12'h499, 12'h187, 1'b0});
    wait_idle("t4_idle", 400);
    frame_hum = 12'h111; frame_temp = 12'h222; frame_neg = 1'b1;
    sv0 = sv_count;
    poke_cnt++;
    step(5);
    chk("t4_spurious_sv", sv_count - sv0, 0);
    chk("t4_spurious_out", {humidity_bcd, temp_bcd, temp_neg}, {12'h499, 12'h187, 1'b0});

    // 5: non-decimal humidity digit is a failure; the automatic retry then succeeds
    frame_hum = 12'hA54; frame_temp = 12'h213; frame_neg = 1'b1;
    base = start_count; sv0 = sv_count;
    pulse_manual();
    wait_start("t5_start", base, GAP + 100);
    step_to(last_start + 205);
    chk("t5_no_sv", sv_count - sv0, 0);
    chk("t5_held", {humidity_bcd, temp_bcd, temp_neg}, {12'h499, 12'h187, 1'b0});
    chk("t5_fail", {fail_count, sensor_fault}, {4'd1, 1'b0});
    frame_hum = 12'h562; frame_temp = 12'h301; frame_neg = 1'b0;
    wait_start("t5_retry_start", base + 1, GAP + 400);
    wait_sv("t5_retry_sample", sv0, 400);
    chk("t5_retry_out", {humidity_bcd, fail_count}, {12'h562, 4'd0});

    // 6: reset mid-read, data_ready on the timeout cycle, manual-only operation
    wait_idle("t6_idle", 400);
    mode = M_HANG;
    base = start_count;
    pulse_manual();
    wait_start("t6_start", base, GAP + 100);
    step(100);
    arstn = 1'b0;
    #1;
    chk("t6_rst_bcd", {humidity_bcd, temp_bcd}, 48'h0);
    chk("t6_rst_flags", {temp_neg, sample_valid, have_sample, busy, fail_count, sensor_fault, start_read}, 48'h0);
    step(3);
    arstn = 1'b1;
    mode = M_TIE; frame_hum = 12'h321; frame_temp = 12'h045; frame_neg = 1'b0;
    step(2);
    base = start_count; sv0 = sv_count;
    pulse_manual();
    wait_start("t6_tie_start", base, 100);
    wait_sv("t6_tie_sample", sv0, TMO + 100);
    chk("t6_tie_out", {humidity_bcd, temp_bcd, temp_neg}, {12'h321, 12'h045, 1'b0});
    chk("t6_tie_flags", {have_sample, fail_count, sensor_fault}, {1'b1, 4'd0, 1'b0});
    wait_idle("t6_idle2", 400);
    mode = M_GOOD;
    base = start_count;
    pulse_manual();
    wait_start("t6_man_start", base, GAP + 100);
    step(POLL + 1500);
    chk("t6_one_read", start_count - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
